// File: rtl/pool_relu_pkg.sv
// Shared definitions for the 2x2 pool + ReLU datapath.
// Average pooling is compiled in only when POOL_RELU_AVG_EN is defined.
package pool_relu_pkg;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  // What a lane does with the incoming sample at the current window position.
  typedef enum logic [1:0] {
    OpIdle,
    OpLoad,
    OpComb,
    OpFinal
  } lane_op_e;

  // Line buffer entry width: two guard bits hold a 4-sample sum in average mode.
  function automatic int unsigned entry_width(int unsigned conv_bit);
`ifdef POOL_RELU_AVG_EN
    return conv_bit + 2;
`else
    return conv_bit;
`endif
  endfunction

  function automatic int unsigned idx_width(int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pool_relu_lane.sv
// One channel of the 2x2 pooler: half-row line buffer, combine, ReLU and result register.
// Average combine exists only when POOL_RELU_AVG_EN is defined.
module pool_relu_lane
  import pool_relu_pkg::*;
#(
  parameter int unsigned CONV_BIT = 12,
  parameter int unsigned IN_WIDTH = 24
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  lane_op_e                             op_i,
  input  logic                                 avg_i,
  input  logic [idx_width(IN_WIDTH / 2)-1:0]   idx_i,
  input  logic signed [CONV_BIT-1:0]           sample_i,
  output logic [CONV_BIT-1:0]                  result_o
);

  localparam int unsigned Depth = IN_WIDTH / 2;
  localparam int unsigned EW    = entry_width(CONV_BIT);

  logic signed [EW-1:0]  buf_q [Depth];
  logic signed [EW-1:0]  entry;
  logic signed [EW-1:0]  samp_ext;
  logic signed [EW-1:0]  comb_c;
  logic signed [EW-1:0]  win_c;
  logic [CONV_BIT-1:0]   res_d, res_q;

  assign entry    = buf_q[idx_i];
  assign samp_ext = EW'(sample_i);

  always_comb begin
    comb_c = (samp_ext > entry) ? samp_ext : entry;
    win_c  = comb_c;
`ifdef POOL_RELU_AVG_EN
    if (avg_i == POOL_AVG) begin
      comb_c = entry + samp_ext;
      win_c  = comb_c >>> 2;
    end
`endif
  end

`ifndef POOL_RELU_AVG_EN
  logic unused_avg;
  assign unused_avg = avg_i;
`endif

  // ReLU: non-positive window results clamp to zero.
  always_comb begin
    res_d = '0;
    if (!win_c[EW-1] && (win_c != '0)) begin
      res_d = CONV_BIT'(win_c);
    end
  end

  // Entries are always loaded before they are read, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (op_i == OpLoad) begin
      buf_q[idx_i] <= samp_ext;
    end else if (op_i == OpComb) begin
      buf_q[idx_i] <= comb_c;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_q <= '0;
    end else if (op_i == OpFinal) begin
      res_q <= res_d;
    end
  end

  assign result_o = res_q;

endmodule

// File: rtl/pool_relu_nch.sv
// Multi-channel 2x2 stride-2 pooling with ReLU over a raster pixel stream.
// Average mode is available only when POOL_RELU_AVG_EN is defined; otherwise max is used.
module pool_relu_nch
  import pool_relu_pkg::*;
#(
  parameter int unsigned CONV_BIT  = 12,
  parameter int unsigned N_CH      = 3,
  parameter int unsigned IN_WIDTH  = 24,
  parameter int unsigned IN_HEIGHT = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      soft_clr,
  input  logic                      mode,
  input  logic                      valid_in,
  input  logic [N_CH*CONV_BIT-1:0]  conv_in,
  output logic [N_CH*CONV_BIT-1:0]  pool_out,
  output logic                      valid_out,
  output logic                      frame_done
);

  localparam int unsigned CW = idx_width(IN_WIDTH);
  localparam int unsigned RW = idx_width(IN_HEIGHT);
  localparam int unsigned IW = idx_width(IN_WIDTH / 2);

  localparam logic [CW-1:0] ColLast = CW'(IN_WIDTH - 1);
  localparam logic [RW-1:0] RowLast = RW'(IN_HEIGHT - 1);

  logic [CW-1:0] col_d, col_q;
  logic [RW-1:0] row_d, row_q;
  logic          valid_d, valid_q;
  logic          done_d, done_q;
  logic          accept;
  logic          avg;
  logic [IW-1:0] idx;
  lane_op_e      op;

  // soft_clr wins over a simultaneous pixel.
  assign accept = valid_in && !soft_clr;
  assign idx    = IW'(col_q >> 1);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (soft_clr) begin
      col_d = '0;
      row_d = '0;
    end else if (valid_in) begin
      if (col_q == ColLast) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    op = OpIdle;
    if (accept) begin
      unique case ({row_q[0], col_q[0]})
        2'b00:   op = OpLoad;
        2'b11:   op = OpFinal;
        default: op = OpComb;
      endcase
    end
  end

  assign valid_d = (op == OpFinal);
  assign done_d  = valid_d && (col_q == ColLast) && (row_q == RowLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

`ifdef POOL_RELU_AVG_EN
  logic mode_d, mode_q;

  // Mode is latched on the first pixel of a frame and held until the next one.
  always_comb begin
    mode_d = mode_q;
    if (accept && (row_q == '0) && (col_q == '0)) begin
      mode_d = mode;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= POOL_MAX;
    end else begin
      mode_q <= mode_d;
    end
  end

  assign avg = mode_q;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign avg         = POOL_MAX;
`endif

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    pool_relu_lane #(
      .CONV_BIT (CONV_BIT),
      .IN_WIDTH (IN_WIDTH)
    ) u_lane (
      .clk_i    (clk),
      .rst_i    (rst),
      .op_i     (op),
      .avg_i    (avg),
      .idx_i    (idx),
      .sample_i (conv_in[g*CONV_BIT +: CONV_BIT]),
      .result_o (pool_out[g*CONV_BIT +: CONV_BIT])
    );
  end

  assign valid_out  = valid_q;
  assign frame_done = done_q;

endmodule
